// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a framed program image byte-by-byte from a UART receiver and
//   writes it word-by-word into the instruction memory programming port.
//   The core is held (cpu_hold) from the moment a frame starts until a frame
//   completes with a good checksum.
//
//   Frame: SYNC_BYTE, count_lo, count_hi, 4*N data bytes (little-endian words),
//          checksum (XOR of all data bytes). N = {count_hi, count_lo}, 1..4096.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   rx_data     received byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   write_addr  word-aligned byte address of the current write
//   write_data  assembled 32-bit instruction word
//   w_en        one-cycle write strobe
//   cpu_hold    high while the core must stay stalled
//   load_done   level, set by a frame that ended with a good checksum
//   load_err    level, set by an aborted frame or a bad checksum
//   dbg_state   current FSM state (encoding of state_t)
//
// Handshake: there is no back-pressure in either direction. A byte is
// consumed on every rising edge where rx_valid is high; the memory accepts a
// word on every rising edge where w_en is high.
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [13:0] write_addr,
   output logic [31:0] write_data,
   output logic        w_en,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        load_err,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CNT_LO = 3'd1,
      CNT_HI = 3'd2,
      DATA   = 3'd3,
      CSUM   = 3'd4
   } state_t;

   localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] MAX_WORDS = 16'd4096;

   state_t      state_q, state_d;
   logic [13:0] addr_d;
   logic [31:0] wdata_d;
   logic        w_en_d;
   logic        hold_d, done_d, err_d;
   logic [7:0]  csum_q, csum_d;
   logic [31:0] tmo_q, tmo_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] word_buf_q, word_buf_d;
   logic [7:0]  count_lo_q, count_lo_d;
   logic [12:0] n_words_q, n_words_d;
   logic [12:0] word_cnt_q, word_cnt_d;
   logic [15:0] n_req;

   assign dbg_state = state_q;
   assign n_req     = {rx_data, count_lo_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         write_addr <= '0;
         write_data <= '0;
         w_en       <= 1'b0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         csum_q     <= '0;
         tmo_q      <= '0;
         byte_idx_q <= '0;
         word_buf_q <= '0;
         count_lo_q <= '0;
         n_words_q  <= '0;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         write_addr <= addr_d;
         write_data <= wdata_d;
         w_en       <= w_en_d;
         cpu_hold   <= hold_d;
         load_done  <= done_d;
         load_err   <= err_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
         byte_idx_q <= byte_idx_d;
         word_buf_q <= word_buf_d;
         count_lo_q <= count_lo_d;
         n_words_q  <= n_words_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = write_addr;
      wdata_d    = write_data;
      w_en_d     = 1'b0;
      hold_d     = cpu_hold;
      done_d     = load_done;
      err_d      = load_err;
      csum_d     = csum_q;
      byte_idx_d = byte_idx_q;
      word_buf_d = word_buf_q;
      count_lo_d = count_lo_q;
      n_words_d  = n_words_q;
      word_cnt_d = word_cnt_q;

      // Idle-gap counter only runs inside a frame.
      if (rx_valid || state_q == IDLE) tmo_d = '0;
      else                             tmo_d = tmo_q + 32'd1;

      // The write strobe is the cycle after the fourth byte; the address
      // advances once the write has been presented. The 14-bit add wraps
      // 3FFC -> 0000 on its own.
      if (w_en) begin
         addr_d     = write_addr + 14'd4;
         word_cnt_d = word_cnt_q + 13'd1;
         if (word_cnt_q == n_words_q - 13'd1) state_d = CSUM;
      end

      case (state_q)
         IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d    = CNT_LO;
               hold_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = 1'b0;
               addr_d     = '0;
               csum_d     = '0;
               byte_idx_d = '0;
               word_cnt_d = '0;
            end
         end
         CNT_LO: begin
            if (rx_valid) begin
               count_lo_d = rx_data;
               state_d    = CNT_HI;
            end
         end
         CNT_HI: begin
            if (rx_valid) begin
               if (n_req == 16'd0 || n_req > MAX_WORDS) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  n_words_d = n_req[12:0];
                  state_d   = DATA;
               end
            end
         end
         DATA: begin
            // A byte equal to SYNC_BYTE lands here as ordinary data.
            if (rx_valid) begin
               csum_d     = csum_q ^ rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_buf_d[7:0]   = rx_data;
                  2'd1: word_buf_d[15:8]  = rx_data;
                  2'd2: word_buf_d[23:16] = rx_data;
                  default: begin
                     w_en_d  = 1'b1;
                     wdata_d = {rx_data, word_buf_q};
                  end
               endcase
            end
         end
         CSUM: begin
            if (rx_valid) begin
               state_d = IDLE;
               if (rx_data == csum_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Timeout overrides everything above; a partially assembled word is
      // dropped simply by restarting the byte index.
      if (state_q != IDLE && !rx_valid && tmo_q == TMO_LAST) begin
         state_d    = IDLE;
         err_d      = 1'b1;
         byte_idx_d = '0;
         tmo_d      = '0;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader with a short timeout. Expected memory
//   writes are queued before each frame and popped by a write monitor.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [13:0] write_addr;
   logic [31:0] write_data;
   logic        w_en;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [2:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   int wen_cnt = 0;

   logic [13:0] exp_addr_q[$];
   logic [31:0] exp_q[$];

   imem_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .write_addr (write_addr),
      .write_data (write_data),
      .w_en       (w_en),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .dbg_state  (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (w_en === 1'b1) begin
         wen_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_wen", 32'(write_addr), 32'hFFFF_FFFF);
         end else begin
            check("wr_addr", 32'(write_addr), 32'(exp_addr_q.pop_front()));
            check("wr_data", write_data, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_write(input logic [13:0] a, input logic [31:0] d);
      exp_addr_q.push_back(a);
      exp_q.push_back(d);
   endtask

   task automatic check_flags(input string tag, input logic hold, input logic done, input logic err);
      check({tag, "_hold"}, 32'(cpu_hold), 32'(hold));
      check({tag, "_done"}, 32'(load_done), 32'(done));
      check({tag, "_err"},  32'(load_err), 32'(err));
   endtask

   // the two-word program used by several steps
   task automatic send_two_words(input logic [7:0] csum);
      expect_write(14'h0000, 32'h0000_0013);
      expect_write(14'h0004, 32'h0010_0093);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(csum);
      idle(2);
   endtask

   initial begin
      int wen_base;
      logic [31:0] w;

      rst      = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      idle(3);

      // reset values
      check("rst_addr",  32'(write_addr), 32'h0);
      check("rst_data",  write_data, 32'h0);
      check("rst_wen",   32'(w_en), 32'h0);
      check("rst_state", 32'(dbg_state), 32'd0);
      check_flags("rst", 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      idle(2);

      // non-sync byte in IDLE is ignored
      send_byte(8'h13);
      idle(2);
      check("ign_state", 32'(dbg_state), 32'd0);
      check_flags("ign", 1'b1, 1'b0, 1'b0);

      // good frame: 13^00^00^00^93^00^10^00 = 90
      send_two_words(8'h90);
      check_flags("good", 1'b0, 1'b1, 1'b0);
      check("good_addr_after", 32'(write_addr), 32'h8);

      // same words, checksum 81 mismatches; writes still happen
      send_two_words(8'h81);
      check_flags("badcs", 1'b1, 1'b0, 1'b1);

      // N = 0: sync clears the error, count rejects the frame
      send_byte(8'hA5);
      idle(1);
      check_flags("n0_sync", 1'b1, 1'b0, 1'b0);
      send_byte(8'h00); send_byte(8'h00);
      idle(2);
      check_flags("n0", 1'b1, 1'b0, 1'b1);
      check("n0_state", 32'(dbg_state), 32'd0);

      // N = 4097 is one too many
      send_byte(8'hA5);
      idle(1);
      check("n4097_sync_err", 32'(load_err), 32'h0);
      send_byte(8'h01); send_byte(8'h10);
      idle(2);
      check_flags("n4097", 1'b1, 1'b0, 1'b1);

      // sync value inside data is plain data; XOR of four A5 is 00
      expect_write(14'h0000, 32'hA5A5_A5A5);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'hA5);
      send_byte(8'h00);
      idle(2);
      check_flags("syncdata", 1'b0, 1'b1, 1'b0);

      // timeout with a half-built word
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      idle(60);
      check("tmo_early_err", 32'(load_err), 32'h0);
      check("tmo_early_state", 32'(dbg_state), 32'd3);
      idle(50);
      check_flags("tmo", 1'b1, 1'b0, 1'b1);
      check("tmo_state", 32'(dbg_state), 32'd0);

      // loader recovers: 78^56^34^12 = 08
      expect_write(14'h0000, 32'h1234_5678);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      send_byte(8'h08);
      idle(2);
      check_flags("recover", 1'b0, 1'b1, 1'b0);

      // reset after six bytes of a two-word frame
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_addr", 32'(write_addr), 32'h0);
      check("midrst_data", write_data, 32'h0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      check_flags("midrst", 1'b1, 1'b0, 1'b0);
      send_byte(8'h00); send_byte(8'h13); send_byte(8'h37);
      idle(3);
      check("garbage_state", 32'(dbg_state), 32'd0);
      check_flags("garbage", 1'b1, 1'b0, 1'b0);

      // full 4096-word image of incrementing words; XOR over it is 00
      wen_base = wen_cnt;
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
      for (int i = 0; i < 4096; i++) begin
         w = 32'(i);
         expect_write(14'(i * 4), w);
         send_byte(w[7:0]); send_byte(w[15:8]);
         send_byte(w[23:16]); send_byte(w[31:24]);
      end
      send_byte(8'h00);
      idle(2);
      check("full_wen_count", 32'(wen_cnt - wen_base), 32'd4096);
      check("full_addr_wrap", 32'(write_addr), 32'h0);
      check("full_last_data", write_data, 32'h0000_0FFF);
      check_flags("full", 1'b0, 1'b1, 1'b0);

      check("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
